// File: rtl/display_timing_720p.sv
// 1280x720p60 timing generator: waits for a stable pixel-clock lock, then emits registered, mutually aligned coordinates, sync, DE and strobes.
// Optional completed-frame counter is built only when DISPLAY_TIMING_FRAME_CNT_EN is defined.
module display_timing_720p #(
  parameter int CORDW       = 16,
  parameter int H_RES       = 1280,
  parameter int H_FP        = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int V_RES       = 720,
  parameter int V_FP        = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20,
  parameter bit H_POL       = 1'b1,
  parameter bit V_POL       = 1'b1,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic                    clk_pix_locked,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame,
  output logic                    line,
  output logic                    running,
  output logic [15:0]             frame_cnt
);

  // Blanking sits at negative coordinates so the active area starts at (0,0).
  localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [CORDW-1:0] HS_STA = CORDW'(-(H_SYNC + H_BP));
  localparam logic signed [CORDW-1:0] HS_END = CORDW'(-H_BP);
  localparam logic signed [CORDW-1:0] HA_END = CORDW'(H_RES - 1);
  localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [CORDW-1:0] VS_STA = CORDW'(-(V_SYNC + V_BP));
  localparam logic signed [CORDW-1:0] VS_END = CORDW'(-V_BP);
  localparam logic signed [CORDW-1:0] VA_END = CORDW'(V_RES - 1);
  localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);
  localparam logic [7:0]              LOCK_LIM = 8'(LOCK_CYCLES);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              lock_cnt, lock_cnt_nxt;
  logic signed [CORDW-1:0] sx_nxt, sy_nxt;
  logic                    run_nxt;
  logic                    hs_act, vs_act, de_nxt, frame_nxt, line_nxt;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state    <= WAIT_LOCK;
      lock_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Next position is decoded here and registered together, so all outputs share one cycle.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    sx_nxt       = H_STA;
    sy_nxt       = V_STA;
    case (state)
      WAIT_LOCK: begin
        if (!clk_pix_locked) begin
          lock_cnt_nxt = 8'd0;
        end else if (lock_cnt + 8'd1 == LOCK_LIM) begin
          state_nxt    = RUN;
          lock_cnt_nxt = 8'd0;
        end else begin
          lock_cnt_nxt = lock_cnt + 8'd1;
        end
      end
      RUN: begin
        if (!clk_pix_locked) begin
          state_nxt    = WAIT_LOCK;
          lock_cnt_nxt = 8'd0;
        end else if (sx == HA_END) begin
          sx_nxt = H_STA;
          sy_nxt = (sy == VA_END) ? V_STA : sy + ONE;
        end else begin
          sx_nxt = sx + ONE;
          sy_nxt = sy;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase

    run_nxt   = (state_nxt == RUN);
    hs_act    = run_nxt && (sx_nxt >= HS_STA) && (sx_nxt < HS_END);
    vs_act    = run_nxt && (sy_nxt >= VS_STA) && (sy_nxt < VS_END);
    de_nxt    = run_nxt && !sx_nxt[CORDW-1] && !sy_nxt[CORDW-1];
    line_nxt  = run_nxt && (sx_nxt == H_STA);
    frame_nxt = line_nxt && (sy_nxt == V_STA);
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sx      <= H_STA;
      sy      <= V_STA;
      hsync   <= ~H_POL;
      vsync   <= ~V_POL;
      de      <= 1'b0;
      frame   <= 1'b0;
      line    <= 1'b0;
      running <= 1'b0;
    end else begin
      sx      <= sx_nxt;
      sy      <= sy_nxt;
      hsync   <= hs_act ? H_POL : ~H_POL;
      vsync   <= vs_act ? V_POL : ~V_POL;
      de      <= de_nxt;
      frame   <= frame_nxt;
      line    <= line_nxt;
      running <= run_nxt;
    end
  end

`ifdef DISPLAY_TIMING_FRAME_CNT_EN
  logic        first_seen;
  logic [15:0] frame_cnt_q;

  // The strobe on entry to RUN starts a frame rather than completing one, so it is skipped.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      first_seen  <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else if (!run_nxt) begin
      first_seen  <= 1'b0;
    end else if (frame_nxt) begin
      first_seen  <= 1'b1;
      if (first_seen) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_display_timing_720p.sv
// Bench for display_timing_720p using a reduced raster so whole frames fit in a short run.
module tb_display_timing_720p;

  localparam int HRES = 16, HFP = 3, HSY = 2, HBP = 4;
  localparam int VRES = 6,  VFP = 1, VSY = 2, VBP = 2;
  localparam int LOCKN = 16;
  localparam bit HPOL = 1'b1, VPOL = 1'b0;
  localparam int HT = HRES + HFP + HSY + HBP;
  localparam int VT = VRES + VFP + VSY + VBP;
  localparam int FRAME_LEN = HT * VT;
  localparam int HSTA = -(HFP + HSY + HBP);
  localparam int HSSTA = HSTA + HFP;
  localparam int HSEND = HSSTA + HSY;
  localparam int VSTA = -(VFP + VSY + VBP);
  localparam int VSSTA = VSTA + VFP;
  localparam int VSEND = VSSTA + VSY;

  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;
  logic clk_pix_locked = 1'b0;
  logic signed [15:0] sx, sy;
  logic hsync, vsync, de, frame, line, running;
  logic [15:0] frame_cnt;

  display_timing_720p #(
    .CORDW(16), .H_RES(HRES), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_RES(VRES), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .H_POL(HPOL), .V_POL(VPOL), .LOCK_CYCLES(LOCKN)
  ) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .clk_pix_locked(clk_pix_locked),
    .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
    .frame(frame), .line(line), .running(running), .frame_cnt(frame_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  int checks = 0;
  int errors = 0;

  // Reference model: lock streak plus a position index counted from RUN entry.
  bit m_run = 1'b0;
  int streak = 0;
  int k = 0;
  int nframes = 0;
  int m_fcnt = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_frame_now();
    return m_run && (k == 0);
  endfunction

  task automatic model_update(input logic r, input logic l);
    if (r) begin
      m_run = 0; streak = 0; k = 0; nframes = 0; m_fcnt = 0;
    end else begin
      if (!m_run) begin
        if (l) begin
          streak++;
          if (streak == LOCKN) begin
            m_run = 1; k = 0; nframes = 0; streak = 0;
          end
        end else begin
          streak = 0;
        end
      end else if (!l) begin
        m_run = 0; streak = 0;
      end else begin
        k = (k + 1) % FRAME_LEN;
      end
      if (m_frame_now()) begin
        if (nframes > 0) m_fcnt = (m_fcnt + 1) % 65536;
        nframes++;
      end
    end
  endtask

  task automatic step(input logic r, input logic l);
    rst_pix = r;
    clk_pix_locked = l;
    @(posedge clk_pix);
    model_update(r, l);
    #1;
  endtask

  task automatic check_model();
    int ex, ey, efc;
    bit ehs, evs, ede, efr, eln;
    ex = m_run ? HSTA + (k % HT) : HSTA;
    ey = m_run ? VSTA + (k / HT) : VSTA;
    ehs = (m_run && ex >= HSSTA && ex < HSEND) ? HPOL : !HPOL;
    evs = (m_run && ey >= VSSTA && ey < VSEND) ? VPOL : !VPOL;
    ede = m_run && ex >= 0 && ey >= 0;
    eln = m_run && ex == HSTA;
    efr = eln && ey == VSTA;
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    efc = m_fcnt;
`else
    efc = 0;
`endif
    chk("model_sx", sx, ex);
    chk("model_sy", sy, ey);
    chk("model_flags{run,hs,vs,de,fr,ln}", {running, hsync, vsync, de, frame, line},
        {m_run, ehs, evs, ede, efr, eln});
    chk("model_frame_cnt", frame_cnt, efc);
  endtask

  typedef struct {
    logic r, l;
    logic run;
    int   ex, ey;
    logic fr, ln, hs, vs, de;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic l, logic run, int ex, int ey, logic fr, logic ln);
    vec_t v;
    v.r = r; v.l = l; v.run = run; v.ex = ex; v.ey = ey; v.fr = fr; v.ln = ln;
    v.hs = !HPOL; v.vs = !VPOL; v.de = 1'b0;
    return v;
  endfunction

  initial begin
    int cnt_fr, cnt_ln, cnt_de, cnt_vs, cnt_hs, first_hs_x;
    logic [15:0] exp_fc;

    // Reset, lock glitch after 10 highs, then 16 clean highs qualify the lock.
    for (int i = 0; i < 2; i++)  tbl.push_back(mk(1, 1, 0, HSTA, VSTA, 0, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 1, 0, HSTA, VSTA, 0, 0));
    tbl.push_back(mk(0, 0, 0, HSTA, VSTA, 0, 0));
    for (int i = 0; i < LOCKN - 1; i++) tbl.push_back(mk(0, 1, 0, HSTA, VSTA, 0, 0));
    tbl.push_back(mk(0, 1, 1, HSTA, VSTA, 1, 1));
    tbl.push_back(mk(0, 1, 1, HSTA + 1, VSTA, 0, 0));
    tbl.push_back(mk(0, 1, 1, HSTA + 2, VSTA, 0, 0));
    tbl.push_back(mk(0, 0, 0, HSTA, VSTA, 0, 0));
    tbl.push_back(mk(1, 1, 0, HSTA, VSTA, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].l);
      chk($sformatf("tbl%0d_running", i), running, tbl[i].run);
      chk($sformatf("tbl%0d_sx", i), sx, tbl[i].ex);
      chk($sformatf("tbl%0d_sy", i), sy, tbl[i].ey);
      chk($sformatf("tbl%0d_fr_ln", i), {frame, line}, {tbl[i].fr, tbl[i].ln});
      chk($sformatf("tbl%0d_hs_vs_de", i), {hsync, vsync, de}, {tbl[i].hs, tbl[i].vs, tbl[i].de});
      if (tbl[i].r) chk($sformatf("tbl%0d_frame_cnt", i), frame_cnt, 0);
    end

    // One complete frame from RUN entry.
    step(1, 0);
    for (int i = 0; i < LOCKN; i++) step(0, 1);
    chk("full_entry_running", running, 1);
    cnt_fr = 0; cnt_ln = 0; cnt_de = 0; cnt_vs = 0; cnt_hs = 0; first_hs_x = 9999;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i > 0) step(0, 1);
      cnt_fr += int'(frame);
      cnt_ln += int'(line);
      cnt_de += int'(de);
      cnt_vs += int'(vsync == VPOL);
      if (hsync == HPOL) begin
        cnt_hs++;
        if (first_hs_x == 9999) first_hs_x = sx;
      end
    end
    chk("full_frame_pulses", cnt_fr, 1);
    chk("full_line_pulses", cnt_ln, VT);
    chk("full_de_cycles", cnt_de, HRES * VRES);
    chk("full_vsync_cycles", cnt_vs, HT * VSY);
    chk("full_hsync_cycles", cnt_hs, VT * HSY);
    chk("first_hsync_sx", first_hs_x, HSSTA);
    chk("pre_wrap_sx", sx, HRES - 1);
    chk("pre_wrap_sy", sy, VRES - 1);
    step(0, 1);
    chk("wrap_sx", sx, HSTA);
    chk("wrap_sy", sy, VSTA);
    chk("wrap_frame", frame, 1);

    // Lock loss mid-frame, then re-lock restarts from the top.
    for (int i = 0; i < (3 - VSTA) * HT + (10 - HSTA); i++) step(0, 1);
    chk("loss_pre_sx", sx, 10);
    chk("loss_pre_sy", sy, 3);
    chk("loss_pre_de", de, 1);
    step(0, 0);
    chk("loss_running", running, 0);
    chk("loss_de", de, 0);
    chk("loss_sx", sx, HSTA);
    chk("loss_sy", sy, VSTA);
    for (int i = 0; i < LOCKN - 1; i++) step(0, 1);
    chk("relock_early_running", running, 0);
    step(0, 1);
    chk("relock_running", running, 1);
    chk("relock_frame", frame, 1);
    chk("relock_sx", sx, HSTA);

    // Frame counter over three full frames, across lock loss, and through reset.
`ifdef DISPLAY_TIMING_FRAME_CNT_EN
    exp_fc = 16'd3;
`else
    exp_fc = 16'd0;
`endif
    step(1, 0);
    for (int i = 0; i < LOCKN; i++) step(0, 1);
    chk("fc_entry", frame_cnt, 0);
    for (int i = 0; i < 3 * FRAME_LEN; i++) step(0, 1);
    chk("fc_three_frames_strobe", frame, 1);
    chk("fc_three_frames", frame_cnt, exp_fc);
    step(0, 0);
    step(0, 0);
    chk("fc_hold_after_loss", frame_cnt, exp_fc);
    step(1, 1);
    chk("fc_after_reset", frame_cnt, 0);

    // Randomised lock activity against the model.
    check_model();
    for (int n = 0; n < 40; n++) begin
      int hi_len;
      hi_len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : $urandom_range(1, 400);
      for (int j = 0; j < hi_len; j++) begin
        step(0, 1);
        check_model();
      end
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        step(0, 0);
        check_model();
      end
      if ($urandom_range(0, 9) == 0) begin
        step(1, $urandom_range(0, 1) == 1);
        check_model();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
